pio_fifo_pair: RTL
==================

Name: pio_fifo_pair

Overview:
- Per-state-machine FIFO pair on the far side of the machine's push/pull interface.
- TX FIFO: the host writes; the machine pulls.
- RX FIFO: the machine pushes; the host reads.
- Supports join modes that merge both storage banks into one double-depth FIFO, plus sticky error flags and level/status outputs for the host register block.

Parameters:
WIDTH, 32, data word width
DEPTH, 4, entries per direction when unjoined; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset; clock clk
join_tx  in  1  config: all 2*DEPTH entries to TX, RX disabled
join_rx  in  1  config: all 2*DEPTH entries to RX, TX disabled (ignored when join_tx=1)
tx_wr  in  1  host write strobe, TX
tx_wdata  in  WIDTH  host write data
pull  in  1  machine pull strobe, TX
din  out  WIDTH  TX head word to machine, first-word-fall-through
empty  out  1  TX empty, to machine
push  in  1  machine push strobe, RX
dout  in  WIDTH  machine push data
full  out  1  RX full, to machine
rx_rd  in  1  host read strobe, RX
rx_rdata  out  WIDTH  RX head word, FWFT
tx_level  out  $clog2(2*DEPTH)+1  TX occupancy
rx_level  out  $clog2(2*DEPTH)+1  RX occupancy
tx_full  out  1  TX full, host status
rx_empty  out  1  RX empty, host status
flag_clr  in  4  write-1-to-clear for flags [3:0]
flags  out  4  sticky {rx_under, rx_stall, tx_stall, tx_over}

Behaviour:
- Capacity: cap_tx = join_tx ? 2*DEPTH : (join_rx ? 0 : DEPTH); cap_rx = join_rx&~join_tx ? 2*DEPTH : (join_tx ? 0 : DEPTH). A 0-capacity FIFO reads as full and empty.
- Storage: one 2*DEPTH x WIDTH array. Unjoined: TX uses entries [0,DEPTH), RX uses [DEPTH,2*DEPTH). Joined: the active FIFO uses all entries.
- Each FIFO has read/write pointers plus a level counter. Pointers wrap at cap_x.
- Reset:
  - pointers, levels and flags = 0;
  - empty=1, rx_empty=1, full=0, tx_full=0.
  - din and rx_rdata = 0 whenever their FIFO is empty.
- Config change: any change of {join_tx, join_rx}, registered and compared against the previous cycle, flushes both FIFOs (pointers/levels to 0) on the next clock. Flags are kept. Strobes in that cycle are ignored.
- FWFT: din = mem[tx_rptr] combinationally while tx_level>0. A pull consumes it at the clock edge and the next word is visible in the following cycle. rx_rdata behaves the same way.
- Write latency: a word written at edge N is visible on din/rx_rdata after edge N; empty deasserts in the same cycle as the level update.
- TX, each clock:
  - wr_ok = tx_wr & (tx_level<cap_tx | pull_ok)
  - pull_ok = pull & tx_level>0
  - level += wr_ok - pull_ok
- TX, simultaneous write and pull:
  - when full, both succeed and the level is unchanged;
  - when empty, the pull fails and the write succeeds.
- RX: same rules with push as the write and rx_rd as the read.
- Flags: set in the cycle after the offending strobe. Set has priority over flag_clr on the same bit.
  - tx_over (bit 0): tx_wr rejected; the data is discarded.
  - tx_stall (bit 1): pull while TX empty. The machine holds pull while blocking, so this re-sets every such cycle.
  - rx_stall (bit 2): push rejected; the data is discarded.
  - rx_under (bit 3): rx_rd while RX empty.
- Status outputs are all registered-state derived, with no combinational path from strobes:
  - empty = tx_level==0
  - full = rx_level==cap_rx
  - tx_full = tx_level==cap_tx
  - rx_empty = rx_level==0
- Reset mid-operation discards all contents immediately.

Test Plan:
- Reset, then 4 tx_wr of 0x11,0x22,0x33,0x44 -> tx_level 1..4, tx_full=1; 5th write 0x55 -> tx_over=1, level stays 4; 4 pulls return 0x11,0x22,0x33,0x44 in order, empty=1 after the last.
- 4 pushes 0xA0..0xA3 -> full=1; push 0xA4 -> rx_stall=1; rx_rd x4 returns 0xA0..0xA3; a 5th rx_rd -> rx_under=1, rx_rdata=0.
- join_tx=1 -> both FIFOs flushed; 8 writes 0..7 accepted, tx_level=8; full=1 and rx_empty=1 constant; 8 pulls return 0..7; wrap verified by a further 3 writes/pulls.
- TX full plus same-cycle tx_wr(0x99)+pull -> pull returns the oldest word, 0x99 is appended, level stays 4, no tx_over.
- TX empty plus same-cycle tx_wr(0x5)+pull -> tx_stall=1, level=1, din=0x5 next cycle; flag_clr=4'b0010 clears tx_stall only.
- 3 words in TX, toggle join_rx -> tx_level=0 and rx_level=0 after one clock, flags unchanged; reset during a burst -> all levels 0, flags 0.

Source files
------------

// File: rtl/pio_fifo_pair.sv
// pio_fifo_pair: TX/RX FWFT FIFO pair sharing one storage array, with join modes,
// sticky error flags and registered-state status for a PIO state machine.
module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      join_tx,
  input  logic                      join_rx,
  input  logic                      tx_wr,
  input  logic [WIDTH-1:0]          tx_wdata,
  input  logic                      pull,
  output logic [WIDTH-1:0]          din,
  output logic                      empty,
  input  logic                      push,
  input  logic [WIDTH-1:0]          dout,
  output logic                      full,
  input  logic                      rx_rd,
  output logic [WIDTH-1:0]          rx_rdata,
  output logic [$clog2(2*DEPTH):0]  tx_level,
  output logic [$clog2(2*DEPTH):0]  rx_level,
  output logic                      tx_full,
  output logic                      rx_empty,
  input  logic [3:0]                flag_clr,
  output logic [3:0]                flags
);
  localparam int AW = $clog2(2*DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] r_mem [2*DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [LW-1:0] r_tx_lvl, r_rx_lvl, w_cap_tx, w_cap_rx;
  logic [1:0] r_cfg;
  logic [3:0] r_flags, w_set;
  logic [AW-1:0] w_rx_base, w_rx_wa, w_rx_ra;
  logic w_chg, w_rx_all, w_tx_rd, w_tx_wr, w_rx_rd, w_rx_wr;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p, input logic [LW-1:0] cap);
    return ({1'b0, p} + LW'(1) == cap) ? '0 : p + AW'(1);
  endfunction

  assign w_chg     = {join_tx, join_rx} != r_cfg;
  assign w_rx_all  = join_rx & ~join_tx;
  assign w_cap_tx  = join_tx ? LW'(2*DEPTH) : (join_rx ? '0 : LW'(DEPTH));
  assign w_cap_rx  = w_rx_all ? LW'(2*DEPTH) : (join_tx ? '0 : LW'(DEPTH));
  assign w_tx_rd   = pull & (r_tx_lvl != '0);
  assign w_tx_wr   = tx_wr & ((r_tx_lvl < w_cap_tx) | w_tx_rd);
  assign w_rx_rd   = rx_rd & (r_rx_lvl != '0);
  assign w_rx_wr   = push & ((r_rx_lvl < w_cap_rx) | w_rx_rd);
  // Unjoined RX lives in the upper half of the shared array
  assign w_rx_base = w_rx_all ? '0 : AW'(DEPTH);
  assign w_rx_wa   = w_rx_base + r_rx_wp;
  assign w_rx_ra   = w_rx_base + r_rx_rp;
  assign w_set     = {rx_rd & (r_rx_lvl == '0), push & ~w_rx_wr,
                      pull & (r_tx_lvl == '0), tx_wr & ~w_tx_wr};

  always_ff @(posedge clk) begin
    if (w_tx_wr & ~w_chg) r_mem[r_tx_wp] <= tx_wdata;
    if (w_rx_wr & ~w_chg) r_mem[w_rx_wa] <= dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg    <= {join_tx, join_rx};
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_tx_lvl <= '0;
      r_rx_lvl <= '0;
      r_flags  <= '0;
    end else begin
      r_cfg   <= {join_tx, join_rx};
      r_flags <= (r_flags & ~flag_clr) | (w_chg ? 4'b0 : w_set);
      if (w_chg) begin
        r_tx_wp  <= '0;
        r_tx_rp  <= '0;
        r_rx_wp  <= '0;
        r_rx_rp  <= '0;
        r_tx_lvl <= '0;
        r_rx_lvl <= '0;
      end else begin
        if (w_tx_wr) r_tx_wp <= f_inc(r_tx_wp, w_cap_tx);
        if (w_tx_rd) r_tx_rp <= f_inc(r_tx_rp, w_cap_tx);
        if (w_rx_wr) r_rx_wp <= f_inc(r_rx_wp, w_cap_rx);
        if (w_rx_rd) r_rx_rp <= f_inc(r_rx_rp, w_cap_rx);
        r_tx_lvl <= r_tx_lvl + LW'(w_tx_wr) - LW'(w_tx_rd);
        r_rx_lvl <= r_rx_lvl + LW'(w_rx_wr) - LW'(w_rx_rd);
      end
    end
  end

  assign empty    = r_tx_lvl == '0;
  assign rx_empty = r_rx_lvl == '0;
  assign full     = r_rx_lvl == w_cap_rx;
  assign tx_full  = r_tx_lvl == w_cap_tx;
  assign din      = empty ? '0 : r_mem[r_tx_rp];
  assign rx_rdata = rx_empty ? '0 : r_mem[w_rx_ra];
  assign tx_level = r_tx_lvl;
  assign rx_level = r_rx_lvl;
  assign flags    = r_flags;
endmodule
